// File: rtl/spi_pkg.sv
// Shared widths, FSM state encoding and counter sizing helpers for the SPI bus arbiter.
package spi_pkg;

    localparam int CMD_W = 16;
    localparam int SS_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module spi_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[(int'(pointer) + i) % NUM_REQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(pointer) + i) % NUM_REQ);
                onehot[(int'(pointer) + i) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ word requesters, round-robin with optional burst lock.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; arbitrate when a request is pending and master ready
//   SETUP  | owner latched, command/ss/cpol/cpha stable toward the master
//   FIRE   | one-cycle trigger pulse
//   SETTLE | ready ignored while the master picks up the trigger
//   WAIT   | wait for ready (completion) or timeout; ack on exit
//   GAP    | ss released, inter-word gap; then re-latch locked owner or idle
module spi_bus_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [CMD_W*NUM_REQ-1:0] cmd_in,
    input  logic [SS_W*NUM_REQ-1:0]  ss_in,
    input  logic [NUM_REQ-1:0]       cpol_in,
    input  logic [NUM_REQ-1:0]       cpha_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CMD_W-1:0]         command,
    output logic [SS_W-1:0]          ss,
    output logic                     cpol,
    output logic                     cpha,
    output logic                     trigger,
    input  logic                     ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(max3(SETTLE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    spi_state_t state;
    spi_state_t next_state;

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pointer;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   sel;

    logic [CMD_W-1:0]   command_r;
    logic [SS_W-1:0]    ss_r;
    logic               cpol_r;
    logic               cpha_r;
    logic [NUM_REQ-1:0] grant_r;

    logic cnt_last;
    logic timed_out;
    logic word_done;
    logic gap_end;
    logic relatch;
    logic arb_latch;
    logic latch_en;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .pointer (pointer),
        .onehot  (pick_onehot),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    // Down-counter reaches its terminal count in the last cycle of a timed state.
    assign cnt_last  = (cnt <= CNT_ONE);
    assign timed_out = (state == ST_WAIT) && !ready && cnt_last;
    assign word_done = (state == ST_WAIT) && (ready || cnt_last);
    assign gap_end   = ((state == ST_GAP) && cnt_last) ||
                       (word_done && (GAP_CYCLES == 0));
    assign relatch   = gap_end && lock[owner] && req[owner];
    assign arb_latch = (state == ST_IDLE) && ready && pick_valid;
    assign latch_en  = arb_latch || relatch;
    assign sel       = arb_latch ? pick_idx : owner;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (arb_latch) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_FIRE;
            ST_FIRE:   next_state = (SETTLE_CYCLES == 0) ? ST_WAIT : ST_SETTLE;
            ST_SETTLE: if (cnt_last) next_state = ST_WAIT;
            ST_WAIT: begin
                if (word_done) begin
                    if (GAP_CYCLES != 0) next_state = ST_GAP;
                    else                 next_state = relatch ? ST_SETUP : ST_IDLE;
                end
            end
            ST_GAP:    if (cnt_last) next_state = relatch ? ST_SETUP : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        trigger = 1'b0;
        busy    = (state != ST_IDLE);
        ss      = '0;
        ack     = '0;
        err     = 1'b0;
        if (state == ST_FIRE) trigger = 1'b1;
        if (state inside {ST_SETUP, ST_FIRE, ST_SETTLE, ST_WAIT}) ss = ss_r;
        if (word_done) ack = grant_r;
        err = timed_out;
    end

    // Shared timer: reloaded on entry to each timed state, saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            case (next_state)
                ST_SETTLE: cnt <= SETTLE_LD;
                ST_WAIT:   cnt <= TIMEOUT_LD;
                ST_GAP:    cnt <= GAP_LD;
                default:   cnt <= '0;
            endcase
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner     <= '0;
            pointer   <= '0;
            grant_r   <= '0;
            command_r <= '0;
            ss_r      <= '0;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
        end else begin
            if (latch_en) begin
                command_r <= cmd_in[int'(sel)*CMD_W +: CMD_W];
                ss_r      <= ss_in[int'(sel)*SS_W +: SS_W];
                cpol_r    <= cpol_in[sel];
                cpha_r    <= cpha_in[sel];
            end
            if (arb_latch) begin
                owner   <= pick_idx;
                grant_r <= pick_onehot;
            end else if (gap_end && !relatch) begin
                grant_r <= '0;
                if (int'(owner) == NUM_REQ - 1) pointer <= '0;
                else                            pointer <= owner + IDX_W'(1);
            end
        end
    end

    assign grant   = grant_r;
    assign command = command_r;
    assign cpol    = cpol_r;
    assign cpha    = cpha_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter with a simple SPI master ready model.
module tb_spi_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SETTLE  = 4;
    localparam int GAP     = 10;
    localparam int TMO     = 200;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ-1:0]    lock = '0;
    logic [16*NUM_REQ-1:0] cmd_in = '0;
    logic [10*NUM_REQ-1:0] ss_in = '0;
    logic [NUM_REQ-1:0]    cpol_in = '0;
    logic [NUM_REQ-1:0]    cpha_in = '0;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [15:0]           command;
    logic [9:0]            ss;
    logic                  cpol;
    logic                  cpha;
    logic                  trigger;
    logic                  ready;

    spi_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock), .cmd_in(cmd_in),
        .ss_in(ss_in), .cpol_in(cpol_in), .cpha_in(cpha_in), .ack(ack), .err(err),
        .grant(grant), .busy(busy), .command(command), .ss(ss), .cpol(cpol),
        .cpha(cpha), .trigger(trigger), .ready(ready)
    );

    always #5 clock = ~clock;

    // Master model: ready drops the cycle after trigger and stays low master_lat cycles.
    int   master_lat = 40;
    logic ready_block = 1'b0;
    logic m_busy;
    int   m_cnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (trigger) begin
            m_busy <= 1'b1;
            m_cnt  <= master_lat;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end
    assign ready = !m_busy && !ready_block;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    int          cyc = 0;
    int          last_ack_cyc = 0;
    int          last_trig_cyc = 0;
    int          rdy_cyc = 0;
    int          grant_cyc = 0;
    int          ack_total = 0;
    int          err_total = 0;
    int          err_with_ack = 0;
    logic        ready_d = 1'b0;
    logic [1:0]  grant_d = '0;
    logic [9:0]  trig_ss = '0;
    logic        trig_cpol = 1'b0;
    int          trig_port_q[$];
    int          ack_port_q[$];
    logic [15:0] trig_cmd_q[$];
    int          trig_gap_q[$];

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (ready && !ready_d && !busy) rdy_cyc = cyc;
            ready_d = ready;
            if (grant != '0 && grant_d == '0) grant_cyc = cyc;
            grant_d = grant;
            if (trigger) begin
                trig_port_q.push_back(oh_idx(grant));
                trig_cmd_q.push_back(command);
                trig_gap_q.push_back(cyc - last_ack_cyc);
                trig_ss       = ss;
                trig_cpol     = cpol;
                last_trig_cyc = cyc;
            end
            if (ack != '0) begin
                ack_total++;
                ack_port_q.push_back(oh_idx(ack));
                last_ack_cyc = cyc;
                if (err) err_with_ack++;
            end
            if (err) err_total++;
        end
    end

    task automatic clear_logs();
        trig_port_q.delete();
        ack_port_q.delete();
        trig_cmd_q.delete();
        trig_gap_q.delete();
        ack_total    = 0;
        err_total    = 0;
        err_with_ack = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int start;
        start = ack_total;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ack_total != start) return;
        end
        check(tag, ack_total - start, 1);
    endtask

    task automatic wait_grant(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            step();
            if (grant != '0) return;
        end
        check(tag, {31'd0, grant != '0}, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy) return;
        end
        check(tag, {31'd0, busy}, 0);
    endtask

    task automatic wait_ready(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            step();
            if (ready) return;
        end
        check(tag, {31'd0, ready}, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ss", ss, 0);
        check("rst_trigger", trigger, 0);
        check("rst_command", command, 0);
        check("rst_ack", ack, 0);
        reset = 1'b0;
        step();

        // 1: single word on port 0, data changes after latch ignored, req dropped early
        clear_logs();
        cmd_in[15:0] = 16'h2600;
        ss_in[9:0]   = 10'b10;
        cpol_in      = 2'b01;
        master_lat   = 40;
        req          = 2'b01;
        wait_grant(20, "t1_grant_timeout");
        cmd_in[15:0] = 16'hFFFF;
        ss_in[9:0]   = 10'h3FF;
        req          = 2'b00;
        wait_ack(200, "t1_ack_timeout");
        wait_idle(40, "t1_idle_timeout");
        check("t1_trig_count", trig_port_q.size(), 1);
        check("t1_command", trig_cmd_q[0], 16'h2600);
        check("t1_ss", trig_ss, 10'b10);
        check("t1_cpol", trig_cpol, 1);
        check("t1_ack_count", ack_total, 1);
        check("t1_ack_port", ack_port_q[0], 0);
        check("t1_err", err_total, 0);
        check("t1_latency", last_ack_cyc - last_trig_cyc, 41);

        // 2: both ports requesting, no lock -> strict rotation from pointer 0
        do_reset();
        clear_logs();
        cmd_in     = {16'hB111, 16'hA000};
        ss_in      = {10'h004, 10'h001};
        master_lat = 20;
        req        = 2'b11;
        for (int k = 0; k < 4; k++) wait_ack(200, "t2_ack_timeout");
        req = 2'b00;
        wait_idle(40, "t2_idle_timeout");
        check("t2_trig_count", trig_port_q.size(), 4);
        for (int k = 0; k < 4; k++) check("t2_trig_port", trig_port_q[k], k % 2);
        for (int k = 0; k < 4; k++) check("t2_ack_port", ack_port_q[k], k % 2);
        for (int k = 1; k < 4; k++) check("t2_gap", trig_gap_q[k], GAP + 3);
        check("t2_cmd_p1", trig_cmd_q[1], 16'hB111);

        // 3: locked 3-word burst on port 1 while port 0 waits
        clear_logs();
        cmd_in = {16'hC001, 16'hD000};
        lock   = 2'b10;
        req    = 2'b10;
        wait_grant(30, "t3_grant_timeout");
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_ack(200, "t3_ack_timeout");
            if (k == 0) cmd_in[31:16] = 16'hC002;
            if (k == 1) cmd_in[31:16] = 16'hC003;
            if (k == 2) begin
                req[1]  = 1'b0;
                lock[1] = 1'b0;
            end
        end
        wait_ack(200, "t3_ack0_timeout");
        req = 2'b00;
        wait_idle(40, "t3_idle_timeout");
        check("t3_trig_count", trig_port_q.size(), 4);
        check("t3_port_w0", trig_port_q[0], 1);
        check("t3_port_w1", trig_port_q[1], 1);
        check("t3_port_w2", trig_port_q[2], 1);
        check("t3_port_last", trig_port_q[3], 0);
        check("t3_cmd_w0", trig_cmd_q[0], 16'hC001);
        check("t3_cmd_w1", trig_cmd_q[1], 16'hC002);
        check("t3_cmd_w2", trig_cmd_q[2], 16'hC003);
        check("t3_cmd_last", trig_cmd_q[3], 16'hD000);
        check("t3_relatch_gap1", trig_gap_q[1], GAP + 2);
        check("t3_relatch_gap2", trig_gap_q[2], GAP + 2);
        check("t3_idle_gap", trig_gap_q[3], GAP + 3);
        check("t3_ack_w2_port", ack_port_q[2], 1);

        // 4: ready stuck low past the timeout
        clear_logs();
        master_lat   = SETTLE + TMO + 60;
        cmd_in[15:0] = 16'h1234;
        req          = 2'b01;
        wait_grant(30, "t4_grant_timeout");
        req = 2'b00;
        wait_ack(400, "t4_ack_timeout");
        check("t4_err_with_ack", err_with_ack, 1);
        check("t4_err_count", err_total, 1);
        check("t4_ack_port", ack_port_q[0], 0);
        check("t4_timeout_len", last_ack_cyc - last_trig_cyc, SETTLE + TMO);
        wait_idle(GAP + 5, "t4_idle_timeout");
        check("t4_busy", busy, 0);
        check("t4_grant", grant, 0);
        wait_ready(200, "t4_ready_timeout");

        // 5: reset in WAIT; pointer was left at port 1
        clear_logs();
        master_lat = 40;
        cmd_in     = {16'h5111, 16'h5000};
        req        = 2'b11;
        wait_grant(30, "t5_grant_timeout");
        check("t5_grant_pre", grant, 2'b10);
        repeat (SETTLE + 3) step();
        check("t5_busy_pre", busy, 1);
        check("t5_ss_pre", ss, 10'h004);
        reset = 1'b1;
        #1;
        check("t5_trigger", trigger, 0);
        check("t5_ss", ss, 0);
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        step();
        step();
        reset = 1'b0;
        check("t5_no_ack", ack_total, 0);
        wait_grant(30, "t5_grant2_timeout");
        check("t5_port0_after_reset", grant, 2'b01);
        req = 2'b00;
        wait_ack(200, "t5_ack_timeout");
        wait_idle(40, "t5_idle_timeout");
        check("t5_ack_port", ack_port_q[0], 0);

        // 6: ready low in IDLE holds off the grant
        clear_logs();
        ready_block  = 1'b1;
        cmd_in[15:0] = 16'h6000;
        req          = 2'b01;
        repeat (6) step();
        check("t6_no_grant", grant, 0);
        check("t6_no_busy", busy, 0);
        ready_block = 1'b0;
        wait_grant(30, "t6_grant_timeout");
        req = 2'b00;
        wait_ack(200, "t6_ack_timeout");
        wait_idle(40, "t6_idle_timeout");
        check("t6_ready_to_grant", grant_cyc - rdy_cyc, 1);
        check("t6_ready_to_trigger", last_trig_cyc - rdy_cyc, 2);
        check("t6_cmd", trig_cmd_q[0], 16'h6000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
